// File: rtl/systolic_matmul_seq.sv
// Sequenced NxN signed matrix multiply on an output-stationary systolic MAC array.
// Optional build macro ACC_SAT_EN saturates results to the signed OUT_W range instead of wrapping.
module systolic_matmul_seq #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int OUT_W  = 2*DATA_W,
    parameter int ACC_W  = 2*DATA_W + $clog2(N)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     abort,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = $clog2(3*N);

`ifdef ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {IDLE, LOAD, COMP, OUT} state_t;
    state_t state, state_nx;

    logic signed [DATA_W-1:0] a_buf [N][N];
    logic signed [DATA_W-1:0] b_buf [N][N];
    // a_sh[i][0] / b_sh[0][j] are the skewed edge registers; the rest are PE pass-through regs
    logic signed [DATA_W-1:0] a_sh  [N][N];
    logic signed [DATA_W-1:0] b_sh  [N][N];
    logic signed [ACC_W-1:0]  acc   [N][N];

    logic [IW-1:0] ld_row, ld_col, o_row, o_col;
    logic          ld_b;
    logic [KW-1:0] k;
    int            kk;
    logic          in_fire, out_fire, ld_last, comp_last, o_last;

    function automatic logic signed [ACC_W-1:0] mac_term(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
        logic signed [2*DATA_W-1:0] p;
        p = a * b;
        return ACC_W'(p);
    endfunction

    function automatic logic signed [OUT_W-1:0] fit(input logic signed [ACC_W-1:0] v);
`ifdef ACC_SAT_EN
        if (v > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
        else if (v < SAT_MIN) return SAT_MIN[OUT_W-1:0];
        else                  return v[OUT_W-1:0];
`else
        return v[OUT_W-1:0];
`endif
    endfunction

    assign kk        = int'(k);
    assign ld_last   = ld_b && (ld_row == IW'(N-1)) && (ld_col == IW'(N-1));
    assign comp_last = (k == KW'(3*N-1));
    assign o_last    = (o_row == IW'(N-1)) && (o_col == IW'(N-1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        done      = 1'b0;
        in_fire   = 1'b0;
        out_fire  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                in_fire  = in_valid;
                if (in_fire) state_nx = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                in_fire  = in_valid;
                if (in_fire && ld_last) state_nx = COMP;
            end
            COMP: begin
                if (comp_last) state_nx = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                out_last  = o_last;
                out_data  = fit(acc[o_row][o_col]);
                out_fire  = out_ready;
                if (out_fire && o_last) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // abort wins over any handshake in the same cycle
        if (abort) begin
            in_fire  = 1'b0;
            out_fire = 1'b0;
            done     = 1'b0;
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_row <= '0; ld_col <= '0; ld_b <= 1'b0;
            o_row  <= '0; o_col  <= '0; k    <= '0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_buf[i][j] <= '0; b_buf[i][j] <= '0;
                    a_sh[i][j]  <= '0; b_sh[i][j]  <= '0;
                    acc[i][j]   <= '0;
                end
            end
        end else if (abort) begin
            ld_row <= '0; ld_col <= '0; ld_b <= 1'b0;
            o_row  <= '0; o_col  <= '0; k    <= '0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_sh[i][j] <= '0; b_sh[i][j] <= '0;
                    acc[i][j]  <= '0;
                end
            end
        end else begin
            // load: A row-major then B row-major; ld_b wraps back to A after the last B
            if (in_fire) begin
                if (!ld_b) a_buf[ld_row][ld_col] <= in_data;
                else       b_buf[ld_row][ld_col] <= in_data;
                if (ld_col == IW'(N-1)) begin
                    ld_col <= '0;
                    if (ld_row == IW'(N-1)) begin
                        ld_row <= '0;
                        ld_b   <= ~ld_b;
                    end else begin
                        ld_row <= ld_row + 1'b1;
                    end
                end else begin
                    ld_col <= ld_col + 1'b1;
                end
                if (ld_last) begin
                    k <= '0;
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            a_sh[i][j] <= '0; b_sh[i][j] <= '0;
                            acc[i][j]  <= '0;
                        end
                    end
                end
            end

            // compute: skewed edge feed, systolic shift, MAC in every PE
            if (state == COMP) begin
                k <= k + 1'b1;
                for (int i = 0; i < N; i++) begin
                    if (kk >= i && kk - i < N) a_sh[i][0] <= a_buf[i][IW'(kk - i)];
                    else                       a_sh[i][0] <= '0;
                    if (kk >= i && kk - i < N) b_sh[0][i] <= b_buf[IW'(kk - i)][i];
                    else                       b_sh[0][i] <= '0;
                end
                for (int i = 0; i < N; i++) begin
                    for (int j = 1; j < N; j++) begin
                        a_sh[i][j] <= a_sh[i][j-1];
                        b_sh[j][i] <= b_sh[j-1][i];
                    end
                end
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        acc[i][j] <= acc[i][j] + mac_term(a_sh[i][j], b_sh[i][j]);
                    end
                end
            end

            // output: row-major index advances only on a handshake
            if (out_fire) begin
                if (o_col == IW'(N-1)) begin
                    o_col <= '0;
                    if (o_row == IW'(N-1)) o_row <= '0;
                    else                   o_row <= o_row + 1'b1;
                end else begin
                    o_col <= o_col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_matmul_seq.sv
// Directed bench for systolic_matmul_seq (N=4, DATA_W=8): identity, signed, overflow,
// backpressure, input gating, abort and asynchronous reset cases.
module tb_systolic_matmul_seq;

    logic        clk;
    logic        reset;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int checks;
    int errors;

    logic [7:0]  a_m [16];
    logic [7:0]  b_m [16];
    logic [15:0] e_m [16];
    bit          pat [4];

    systolic_matmul_seq #(.N(4), .DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_identity();
        for (int n = 0; n < 16; n++) begin
            a_m[n] = (n / 4 == n % 4) ? 8'd1 : 8'd0;
            b_m[n] = 8'(n + 1);
            e_m[n] = 16'(n + 1);
        end
    endtask

    task automatic load_job();
        for (int n = 0; n < 32; n++) begin
            in_valid = 1'b1;
            in_data  = (n < 16) ? a_m[n] : b_m[n - 16];
            #1;
            if (n == 0) check("load_ready", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
    endtask

    // waits for out_valid; returns the cycle count counting the accepting edge as 1
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            step();
            lat++;
        end
    endtask

    task automatic drain(input bit bp);
        int          got;
        int          cyc;
        bit          stalled;
        logic [15:0] held;
        logic        held_last;
        got = 0; cyc = 0; stalled = 0; held = '0; held_last = 1'b0;
        while (got < 16 && cyc < 400) begin
            out_ready = bp ? pat[cyc % 4] : 1'b1;
            #1;
            if (stalled) begin
                check("stall_data", out_data, held);
                check("stall_last", out_last, held_last);
            end
            if (out_valid && out_ready) begin
                check($sformatf("data[%0d]", got), out_data, e_m[got]);
                check($sformatf("last[%0d]", got), out_last, (got == 15));
                check($sformatf("done[%0d]", got), done, (got == 15));
                got++;
                stalled = 0;
            end else if (out_valid) begin
                check("done_stall", done, 0);
                stalled   = 1;
                held      = out_data;
                held_last = out_last;
            end
            step();
            cyc++;
        end
        check("drain_count", got, 16);
        out_ready = 1'b0;
        #1;
        check("post_valid", out_valid, 0);
        check("post_ready", in_ready, 1);
        check("post_busy", busy, 0);
        check("post_done", done, 0);
    endtask

    task automatic quiet(input string tag, input int cycles);
        bit seen;
        seen = 0;
        for (int c = 0; c < cycles; c++) begin
            step();
            if (out_valid) seen = 1;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        int lat;
        checks = 0; errors = 0;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        reset = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b1;
        step();

        // identity, in_valid held and out_ready high during compute
        set_identity();
        load_job();
        in_valid  = 1'b1;
        in_data   = 8'h55;
        out_ready = 1'b1;
        #1;
        check("comp_in_ready", in_ready, 0);
        check("comp_busy", busy, 1);
        check("comp_out_valid", out_valid, 0);
        wait_out(lat);
        check("latency", lat, 13);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drain(0);

        // signed, back-to-back, with backpressure
        for (int n = 0; n < 16; n++) begin
            a_m[n] = 8'hFF;
            b_m[n] = 8'd3;
            e_m[n] = 16'hFFF4;
        end
        load_job();
        wait_out(lat);
        check("signed_latency", lat, 13);
        drain(1);

        // overflow of the OUT_W range
        for (int n = 0; n < 16; n++) begin
            a_m[n] = 8'h80;
            b_m[n] = 8'h80;
`ifdef ACC_SAT_EN
            e_m[n] = 16'h7FFF;
`else
            e_m[n] = 16'h0000;
`endif
        end
        load_job();
        wait_out(lat);
        drain(0);

        // abort at COMP k=5
        set_identity();
        load_job();
        for (int c = 0; c < 5; c++) step();
        check("abort_pre_busy", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        quiet("abort_no_out", 20);

        // asynchronous reset mid-OUT
        load_job();
        wait_out(lat);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) step();
        out_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        step();
        reset = 1'b1;
        quiet("rst_no_out", 20);

        // fresh identity job after reset
        load_job();
        wait_out(lat);
        check("final_latency", lat, 13);
        drain(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
